mp1_cache: RTL and testbench

Direct-mapped, write-back, write-allocate cache between the mp1 CPU memory port and a 256-bit line-oriented physical memory. It answers CPU word reads and byte-masked writes from an 8-line array. On a miss it writes back the dirty victim line, then fills the line from physical memory. Upstream it presents the same handshake the CPU drives (read/write held until `mem_resp`); downstream it issues whole-line bursts.

---
 rtl/mp1_cache.sv | 120 ++++++++++++
 tb/tb_mp1_cache.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mp1_cache.sv
// mp1_cache: direct-mapped write-back write-allocate cache, 8 x 256-bit lines.
// Hits answer in the request cycle; misses write back a dirty victim then fill.
module mp1_cache #(
   parameter int S_INDEX = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [3:0]   mem_byte_enable,
   input  logic [31:0]  mem_address,
   input  logic [31:0]  mem_wdata,
   output logic         mem_resp,
   output logic [31:0]  mem_rdata,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_address,
   output logic [255:0] pmem_wdata,
   input  logic [255:0] pmem_rdata,
   input  logic         pmem_resp
);
   localparam int SETS = 1 << S_INDEX;
   localparam int TAGW = 27 - S_INDEX;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

   state_t            state;
   logic [SETS-1:0]   valid;
   logic [SETS-1:0]   dirty;
   logic [TAGW-1:0]   tags [SETS];
   logic [255:0]      data [SETS];

   logic [S_INDEX-1:0] idx;
   logic [TAGW-1:0]    tag;
   logic [2:0]         woff;
   logic               req;
   logic               hit;
   logic [255:0]       merged;
   logic               unused_bits;

   assign idx         = mem_address[4+S_INDEX:5];
   assign tag         = mem_address[31:5+S_INDEX];
   assign woff        = mem_address[4:2];
   assign unused_bits = ^mem_address[1:0];
   assign req         = mem_read | mem_write;
   assign hit         = valid[idx] && (tags[idx] == tag);

   assign mem_resp   = (state == IDLE) && req && hit;
   assign mem_rdata  = data[idx][32*int'(woff) +: 32];
   assign pmem_wdata = data[idx];

   always_comb begin
      merged = data[idx];
      for (int i = 0; i < 4; i++)
         if (mem_byte_enable[i])
            merged[32*int'(woff) + 8*i +: 8] = mem_wdata[8*i +: 8];
   end

   always_comb begin
      pmem_address = '0;
      if (state == WRITEBACK)
         pmem_address = {tags[idx], idx, 5'b0};
      else if (state == ALLOCATE)
         pmem_address = {mem_address[31:5], 5'b0};
   end

   // Reset wins over pmem_resp, so an in-flight line is never committed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         valid      <= '0;
         dirty      <= '0;
         pmem_read  <= 1'b0;
         pmem_write <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req && hit) begin
                  if (mem_write) begin
                     data[idx]  <= merged;
                     dirty[idx] <= 1'b1;
                  end
               end else if (req) begin
                  if (valid[idx] && dirty[idx]) begin
                     state      <= WRITEBACK;
                     pmem_write <= 1'b1;
                  end else begin
                     state     <= ALLOCATE;
                     pmem_read <= 1'b1;
                  end
               end
            end
            WRITEBACK: begin
               if (pmem_resp) begin
                  dirty[idx] <= 1'b0;
                  state      <= ALLOCATE;
                  pmem_write <= 1'b0;
                  pmem_read  <= 1'b1;
               end
            end
            ALLOCATE: begin
               if (pmem_resp) begin
                  data[idx]  <= pmem_rdata;
                  tags[idx]  <= tag;
                  valid[idx] <= 1'b1;
                  dirty[idx] <= 1'b0;
                  state      <= IDLE;
                  pmem_read  <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               pmem_read  <= 1'b0;
               pmem_write <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mp1_cache.sv
// tb_mp1_cache: directed cycle-by-cycle checks of mp1_cache.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_mp1_cache;
   logic         clk = 1'b0;
   logic         rst;
   logic         mem_read;
   logic         mem_write;
   logic [3:0]   mem_byte_enable;
   logic [31:0]  mem_address;
   logic [31:0]  mem_wdata;
   logic         mem_resp;
   logic [31:0]  mem_rdata;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;

   int nvec = 0;
   int nerr = 0;

   mp1_cache dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] mkline(input logic [31:0] base);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
      return l;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic rd, input logic wr,
                      input logic [31:0] a, input logic pr);
      @(negedge clk);
      rst = r; mem_read = rd; mem_write = wr;
      mem_address = a; pmem_resp = pr;
      #1;
   endtask

   task automatic pm(input string tag, input logic r, input logic w,
                     input logic [31:0] a);
      chk({tag, "_pread"}, 256'(pmem_read), 256'(r));
      chk({tag, "_pwrite"}, 256'(pmem_write), 256'(w));
      chk({tag, "_paddr"}, 256'(pmem_address), 256'(a));
   endtask

   initial begin
      mem_byte_enable = 4'h0;
      mem_wdata       = '0;
      pmem_rdata      = '0;

      cyc(1, 0, 0, 32'h0, 0);
      cyc(1, 0, 0, 32'h0, 0);
      chk("rst_resp", 256'(mem_resp), 256'(0));
      pm("rst", 0, 0, 32'h0);

      // clean miss on 0x40, fill after 3 wait cycles
      cyc(0, 1, 0, 32'h40, 0);
      chk("miss40_resp", 256'(mem_resp), 256'(0));
      pm("miss40", 0, 0, 32'h0);
      pmem_rdata = mkline(32'h1000_0000);
      for (int c = 0; c < 4; c++) begin
         cyc(0, 1, 0, 32'h40, c == 3);
         pm($sformatf("fill40_c%0d", c), 1, 0, 32'h40);
         chk($sformatf("fill40_resp_c%0d", c), 256'(mem_resp), 256'(0));
      end
      cyc(0, 1, 0, 32'h40, 0);
      chk("hit40_resp", 256'(mem_resp), 256'(1));
      chk("hit40_rdata", 256'(mem_rdata), 256'(32'h1000_0000));
      pm("hit40", 0, 0, 32'h0);

      cyc(0, 1, 0, 32'h44, 0);
      chk("hit44_resp", 256'(mem_resp), 256'(1));
      chk("hit44_rdata", 256'(mem_rdata), 256'(32'h1000_0001));

      mem_byte_enable = 4'b0101;
      mem_wdata       = 32'hAABB_CCDD;
      cyc(0, 0, 1, 32'h48, 0);
      chk("wr48_resp", 256'(mem_resp), 256'(1));
      cyc(0, 1, 0, 32'h48, 0);
      chk("rd48_resp", 256'(mem_resp), 256'(1));
      chk("rd48_rdata", 256'(mem_rdata), 256'(32'h10BB_00DD));
      mem_byte_enable = 4'h0;

      // stray pmem_resp with nothing outstanding
      pmem_rdata = mkline(32'hDEAD_0000);
      cyc(0, 0, 0, 32'h0, 1);
      chk("stray_resp", 256'(mem_resp), 256'(0));
      pm("stray", 0, 0, 32'h0);
      cyc(0, 1, 0, 32'h48, 0);
      chk("stray_rd48_resp", 256'(mem_resp), 256'(1));
      chk("stray_rd48_rdata", 256'(mem_rdata), 256'(32'h10BB_00DD));

      // dirty eviction by 0x140
      cyc(0, 1, 0, 32'h140, 0);
      chk("miss140_resp", 256'(mem_resp), 256'(0));
      pm("miss140", 0, 0, 32'h0);
      for (int c = 0; c < 2; c++) begin
         cyc(0, 1, 0, 32'h140, c == 1);
         pm($sformatf("wb40_c%0d", c), 0, 1, 32'h40);
         chk($sformatf("wb40_word2_c%0d", c),
             256'(pmem_wdata[95:64]), 256'(32'h10BB_00DD));
         chk($sformatf("wb40_resp_c%0d", c), 256'(mem_resp), 256'(0));
      end
      pmem_rdata = mkline(32'h2000_0000);
      for (int c = 0; c < 2; c++) begin
         cyc(0, 1, 0, 32'h140, c == 1);
         pm($sformatf("fill140_c%0d", c), 1, 0, 32'h140);
      end
      cyc(0, 1, 0, 32'h140, 0);
      chk("hit140_resp", 256'(mem_resp), 256'(1));
      chk("hit140_rdata", 256'(mem_rdata), 256'(32'h2000_0000));
      pm("hit140", 0, 0, 32'h0);

      // clean eviction by 0x240
      cyc(0, 1, 0, 32'h240, 0);
      chk("miss240_resp", 256'(mem_resp), 256'(0));
      pm("miss240", 0, 0, 32'h0);
      pmem_rdata = mkline(32'h3000_0000);
      cyc(0, 1, 0, 32'h240, 1);
      pm("fill240", 1, 0, 32'h240);
      cyc(0, 1, 0, 32'h240, 0);
      chk("hit240_resp", 256'(mem_resp), 256'(1));
      chk("hit240_rdata", 256'(mem_rdata), 256'(32'h3000_0000));
      cyc(0, 1, 0, 32'h25C, 0);
      chk("hit25c_rdata", 256'(mem_rdata), 256'(32'h3000_0007));

      // reset two cycles into the fill of 0x80, with a colliding pmem_resp
      cyc(0, 1, 0, 32'h80, 0);
      chk("miss80_resp", 256'(mem_resp), 256'(0));
      pmem_rdata = mkline(32'h5000_0000);
      cyc(0, 1, 0, 32'h80, 0);
      pm("fill80a", 1, 0, 32'h80);
      cyc(1, 1, 0, 32'h80, 1);
      pm("fill80b", 1, 0, 32'h80);
      cyc(0, 1, 0, 32'h80, 0);
      chk("postrst_resp", 256'(mem_resp), 256'(0));
      pm("postrst", 0, 0, 32'h0);
      pmem_rdata = mkline(32'h4000_0000);
      cyc(0, 1, 0, 32'h80, 1);
      pm("refill80", 1, 0, 32'h80);
      cyc(0, 1, 0, 32'h80, 0);
      chk("hit80_resp", 256'(mem_resp), 256'(1));
      chk("hit80_rdata", 256'(mem_rdata), 256'(32'h4000_0000));

      cyc(0, 0, 0, 32'h0, 0);
      chk("end_resp", 256'(mem_resp), 256'(0));
      pm("end", 0, 0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
